cordic: RTL and testbench
=========================

Name: cordic

Overview:
- Iterative (one micro-rotation per clock) CORDIC engine in fixed point.
- Rotation mode (default) turns a unit vector by theta_i to produce cos/sin.
- Vectoring mode drives y to zero to produce atan(y/x).
- Serves as the shared trig primitive for datapath blocks needing sin/cos or phase of 17-bit signed samples.

Parameters:
- XY_BITS, 16: MSB index of x/y words; words are XY_BITS+1 = 17 bits, two's complement, 1.0 = 32768.
- THETA_BITS, 16: MSB index of angle words; 17 bits, two's complement, radians*32768 (pi/2 = 51471).
- ITERATIONS, 16: number of micro-rotations; must be <= 17.
- VECTOR, 0: 0 = rotation mode, 1 = vectoring mode.
- CORDIC_1, 19898: gain-compensated unit (0.607253*32768); callers load it as x_i in rotation mode.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active low
- init  input  1  load strobe; sampled on rising clk
- x_i  input  17  initial x
- y_i  input  17  initial y
- theta_i  input  17  initial angle (radians*32768)
- x_o  output  17  current x register
- y_o  output  17  current y register
- theta_o  output  17  current angle register

Behaviour:
- Internal registers: x, y, z (17 bits each) and iteration counter k (5 bits). Outputs are driven directly from x, y, z.
- Reset (rst=0, asynchronous): x = y = z = 0 and k = ITERATIONS, i.e. idle. Outputs read 0 until the first init.
- init=1 at a clock edge: x <= x_i, y <= y_i, z <= theta_i, k <= 0.
  - init has priority over any iteration in progress; an in-flight computation is discarded and restarted.
- init=0 and k < ITERATIONS, at each clock edge, step i = k:
  - Direction d: rotation mode d = +1 if z >= 0, else -1. Vectoring mode d = +1 if y < 0, else -1.
  - x <= x - d*(y >>> i)
  - y <= y + d*(x >>> i)
  - z <= z - d*atan_tab[i]
  - k <= k + 1
  - All updates use the pre-edge values. Shifts are arithmetic; adds wrap at 17 bits with no saturation.
- init=0 and k = ITERATIONS: all registers hold. The result stays stable indefinitely.
- Latency: 1 load clock + ITERATIONS clocks. With default parameters, results are valid after the 17th rising edge counted from the init edge.
- atan_tab[0..15] (round(atan(2^-i)*32768)): 25736, 15193, 8027, 4075, 2045, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1.
- Rotation result, with x_i = CORDIC_1, y_i = 0:
  - x_o ~ cos(theta)*32768, y_o ~ sin(theta)*32768, each within +/-10 LSB; z -> ~0.
  - Valid input range |theta_i| <= 51471.
- Vectoring result, with theta_i = 0 and x_i >= 0:
  - theta_o ~ atan(y_i/x_i)*32768 within +/-33 LSB (0.001 rad); y -> ~0.
  - x_o ~ 1.6468*sqrt(x_i^2 + y_i^2); magnitude inputs <= 32768 do not overflow.
- Boundaries:
  - theta = 0 in rotation mode: d = +1 at step 0; converges to cos ~ 32768, sin ~ 0.
  - x_i = 0, y_i = 32768 in vectoring mode: theta_o ~ 51471.
  - Inputs changing while not in init are ignored.
  - init held high continuously keeps reloading; no iteration progresses.

Test Plan:
- Rotate 0 deg: x_i=19898, y_i=0, theta_i=0, init pulse, 16 clocks -> x_o=32768+/-10, y_o=0+/-10.
- Rotate 30/45/90 deg:
  - theta_i=17157 -> x_o~28377, y_o~16383.
  - theta_i=25735 -> x_o~y_o~23170.
  - theta_i=51471 -> x_o~0, y_o~32768 (all +/-10).
- Sweep 0..90 deg in 1-degree steps (theta_i=round(j*pi/180*32768)), each with init + 16 clocks -> every result within +/-10 LSB of round(cos/sin*32768).
- Vectoring (VECTOR=1):
  - x_i=23170, y_i=23170 -> theta_o=25736+/-33.
  - x_i=28377, y_i=16383 -> theta_o~17157+/-33.
  - x_i=0, y_i=32768 -> theta_o~51471+/-33.
- Control:
  - Assert rst low mid-iteration -> outputs 0 immediately (asynchronous); registers hold after release until init.
  - Re-assert init at iteration 8 with new theta -> result matches the new angle after 16 further clocks.
  - After completion, extra clocks leave outputs unchanged.

Source files
------------

// File: rtl/cordic.sv
// Iterative CORDIC engine that performs one micro-rotation per clock.
// Rotation mode (VECTOR=0) rotates (x,y) by z and drives z toward 0.
// Vectoring mode (VECTOR=1) drives y toward 0 and accumulates the angle in z.
module cordic #(
  parameter int XY_BITS    = 16,
  parameter int THETA_BITS = 16,
  parameter int ITERATIONS = 16,
  parameter int VECTOR     = 0,
  parameter int CORDIC_1   = 19898
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [XY_BITS:0]    x_i,
  input  logic [XY_BITS:0]    y_i,
  input  logic [THETA_BITS:0] theta_i,
  output logic [XY_BITS:0]    x_o,
  output logic [XY_BITS:0]    y_o,
  output logic [THETA_BITS:0] theta_o
);

  typedef logic signed [XY_BITS:0]    xy_t;
  typedef logic signed [THETA_BITS:0] theta_t;

  localparam logic [4:0] K_DONE = 5'(ITERATIONS);

  // Reject parameter sets the 5-bit counter and the atan table cannot serve.
  if (ITERATIONS > 17 || ITERATIONS < 1 || CORDIC_1 <= 0) begin : g_bad_param
    $error("cordic: ITERATIONS must be 1..17 and CORDIC_1 positive");
  end

  xy_t        x, y;
  theta_t     z;
  logic [4:0] k;

  xy_t        x_sh, y_sh, x_nxt, y_nxt;
  theta_t     z_nxt, atan_k;
  logic       d_pos;

  // round(atan(2^-i) * 32768); steps past the table contribute nothing.
  function automatic theta_t atan_at(input logic [4:0] i);
    int v;
    case (i)
      5'd0:    v = 25736;
      5'd1:    v = 15193;
      5'd2:    v = 8027;
      5'd3:    v = 4075;
      5'd4:    v = 2045;
      5'd5:    v = 1024;
      5'd6:    v = 512;
      5'd7:    v = 256;
      5'd8:    v = 128;
      5'd9:    v = 64;
      5'd10:   v = 32;
      5'd11:   v = 16;
      5'd12:   v = 8;
      5'd13:   v = 4;
      5'd14:   v = 2;
      5'd15:   v = 1;
      default: v = 0;
    endcase
    return theta_t'(v);
  endfunction

  // Next micro-rotation computed from the current register values.
  always_comb begin
    x_sh   = x >>> k;
    y_sh   = y >>> k;
    atan_k = atan_at(k);
    d_pos  = (VECTOR != 0) ? y[XY_BITS] : ~z[THETA_BITS];
    if (d_pos) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_k;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_k;
    end
  end

  // Load on init (overrides any step in flight), iterate until k reaches ITERATIONS, then hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
      k <= K_DONE;
    end else if (init) begin
      x <= xy_t'(x_i);
      y <= xy_t'(y_i);
      z <= theta_t'(theta_i);
      k <= '0;
    end else if (k < K_DONE) begin
      x <= x_nxt;
      y <= y_nxt;
      z <= z_nxt;
      k <= k + 5'd1;
    end
  end

  assign x_o     = x;
  assign y_o     = y;
  assign theta_o = z;

endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: one rotation-mode and one vectoring-mode
// instance, checked against real-valued trig computed inside the bench.
module tb_cordic;

  localparam real SCALE = 32768.0;
  localparam real PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               r_init = 1'b0;
  logic        [16:0] r_x_i = '0, r_y_i = '0, r_t_i = '0;
  logic signed [16:0] r_x_o, r_y_o, r_t_o;

  logic               v_init = 1'b0;
  logic        [16:0] v_x_i = '0, v_y_i = '0, v_t_i = '0;
  logic signed [16:0] v_x_o, v_y_o, v_t_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic #(.XY_BITS(16), .THETA_BITS(16), .ITERATIONS(16), .VECTOR(0), .CORDIC_1(19898)) u_rot (
    .clk(clk), .rst(rst), .init(r_init),
    .x_i(r_x_i), .y_i(r_y_i), .theta_i(r_t_i),
    .x_o(r_x_o), .y_o(r_y_o), .theta_o(r_t_o)
  );

  cordic #(.XY_BITS(16), .THETA_BITS(16), .ITERATIONS(16), .VECTOR(1), .CORDIC_1(19898)) u_vec (
    .clk(clk), .rst(rst), .init(v_init),
    .x_i(v_x_i), .y_i(v_y_i), .theta_i(v_t_i),
    .x_o(v_x_o), .y_o(v_y_o), .theta_o(v_t_o)
  );

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic check(input string tag, input int got, input int exp, input int tol);
    total++;
    if (got - exp > tol || exp - got > tol) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  task automatic start_rot(input int theta);
    @(negedge clk);
    r_x_i  = 17'(19898);
    r_y_i  = '0;
    r_t_i  = 17'(theta);
    r_init = 1'b1;
    @(negedge clk);
    r_init = 1'b0;
  endtask

  task automatic check_rot(input string tag, input int theta);
    real a;
    a = theta / SCALE;
    check({tag, ".cos"}, int'(r_x_o), rnd($cos(a) * SCALE), 10);
    check({tag, ".sin"}, int'(r_y_o), rnd($sin(a) * SCALE), 10);
    check({tag, ".z"},   int'(r_t_o), 0, 10);
  endtask

  task automatic rot(input string tag, input int theta);
    start_rot(theta);
    repeat (16) @(negedge clk);
    check_rot(tag, theta);
  endtask

  task automatic vec(input string tag, input int x, input int y);
    @(negedge clk);
    v_x_i  = 17'(x);
    v_y_i  = 17'(y);
    v_t_i  = '0;
    v_init = 1'b1;
    @(negedge clk);
    v_init = 1'b0;
    repeat (16) @(negedge clk);
    check({tag, ".ang"}, int'(v_t_o), rnd($atan2(real'(y), real'(x)) * SCALE), 33);
    check({tag, ".mag"}, int'(v_x_o), rnd(1.6468 * $sqrt(real'(x) * x + real'(y) * y)), 30);
    check({tag, ".y"},   int'(v_y_o), 0, 16);
  endtask

  initial begin
    int th, th2, xx, yy;
    real phi, r;

    // Asynchronous reset from time zero: everything reads 0.
    #1 rst = 1'b0;
    #1;
    check("rst.rx", int'(r_x_o), 0, 0);
    check("rst.ry", int'(r_y_o), 0, 0);
    check("rst.rz", int'(r_t_o), 0, 0);
    check("rst.vx", int'(v_x_o), 0, 0);
    check("rst.vy", int'(v_y_o), 0, 0);
    check("rst.vz", int'(v_t_o), 0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle.rx", int'(r_x_o), 0, 0);
    check("idle.vz", int'(v_t_o), 0, 0);

    // Directed rotation angles.
    rot("rot0",   0);
    rot("rot30",  17157);
    rot("rot45",  25735);
    rot("rot90",  51471);
    rot("rotm90", -51471);

    // Extra clocks after completion leave the result in place.
    repeat (25) @(negedge clk);
    check_rot("hold", -51471);

    // Sweep 0..90 degrees.
    for (int j = 0; j <= 90; j++) begin
      th = rnd(j * PI / 180.0 * SCALE);
      rot($sformatf("sweep%0d", j), th);
    end

    // Random angles over the full valid range.
    for (int n = 0; n < 40; n++) begin
      th = int'($urandom_range(102942, 0)) - 51471;
      rot($sformatf("rrot%0d", n), th);
    end

    // init held high keeps reloading; no step is taken.
    @(negedge clk);
    r_x_i = 17'(12345); r_y_i = 17'(-2222); r_t_i = 17'(3000); r_init = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_init.x", int'(r_x_o), 12345, 0);
    check("hold_init.y", int'(r_y_o), -2222, 0);
    check("hold_init.z", int'(r_t_o), 3000, 0);
    r_init = 1'b0;

    // Input changes outside init are ignored.
    start_rot(20000);
    for (int n = 0; n < 16; n++) begin
      r_x_i = 17'($urandom);
      r_y_i = 17'($urandom);
      r_t_i = 17'($urandom);
      @(negedge clk);
    end
    check_rot("ignore", 20000);

    // Restart mid-computation with a new angle.
    th  = -30000;
    th2 = 40000;
    start_rot(th);
    repeat (7) @(negedge clk);
    start_rot(th2);
    repeat (16) @(negedge clk);
    check_rot("reinit", th2);

    // Asynchronous reset mid-iteration clears immediately and stays idle.
    start_rot(33000);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst.x", int'(r_x_o), 0, 0);
    check("arst.y", int'(r_y_o), 0, 0);
    check("arst.z", int'(r_t_o), 0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_idle.x", int'(r_x_o), 0, 0);
    check("arst_idle.y", int'(r_y_o), 0, 0);
    check("arst_idle.z", int'(r_t_o), 0, 0);
    rot("recover", 33000);

    // Vectoring directed cases.
    vec("vec45", 23170, 23170);
    vec("vec30", 28377, 16383);
    vec("vec90", 0, 32768);

    // Vectoring with random vectors in the right half-plane.
    for (int n = 0; n < 30; n++) begin
      phi = (real'(int'($urandom_range(20000, 0)) - 10000) / 10000.0) * (PI / 2.0);
      r   = real'($urandom_range(32767, 4096));
      xx  = rnd(r * $cos(phi));
      yy  = rnd(r * $sin(phi));
      if (xx < 0) xx = 0;
      vec($sformatf("rvec%0d", n), xx, yy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
